// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM read arbiter.
// Holds the FSM state, the return-routing tag and the depth default.
package sdram_arb_pkg;

  localparam int MAXOUT_DEF = 4;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } state_e;

  typedef struct packed {
    logic       owner;
    logic [7:0] beats;
  } tag_t;

endpackage

// File: rtl/arb_tag_fifo.sv
// Show-ahead tag FIFO recording owner and length of issued bursts.
// Head is valid whenever empty is low; count is the live occupancy.
module arb_tag_fifo
  import sdram_arb_pkg::*;
#(
  parameter int DEPTH = MAXOUT_DEF,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  tag_t        din,
  input  logic        pop,
  output tag_t        head,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  tag_t          mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sdram_rd_arbiter.sv
// Two-requester round-robin Avalon burst-read arbiter.
// Return beats are routed in issue order via a tag FIFO.
module sdram_rd_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int BUSW   = 128,
  parameter int MAXOUT = MAXOUT_DEF,
  localparam int CW    = $clog2(MAXOUT) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0][31:0]     rq_address,
  input  logic [1:0]           rq_read,
  input  logic [1:0][7:0]      rq_burstcount,
  output logic [1:0]           rq_waitrequest,
  output logic [BUSW-1:0]      rq_readdata,
  output logic [1:0]           rq_readdatavalid,
  output logic [31:0]          avm_address,
  output logic                 avm_read,
  output logic [7:0]           avm_burstcount,
  input  logic [BUSW-1:0]      avm_readdata,
  input  logic                 avm_readdatavalid,
  input  logic                 avm_waitrequest,
  output logic [CW-1:0]        outstanding,
  output logic                 err_orphan
);

  state_e     state;
  logic       prio;
  logic       owner_q;
  logic [7:0] beat_cnt;
  logic [1:0] gnt;
  logic       sel;
  logic       can_grant;
  logic       push;
  logic       hit;
  logic       last;
  tag_t       head;
  tag_t       din;
  logic       full;
  logic       empty;

  assign can_grant = rst_n && (state == S_IDLE) && !full;

  always_comb begin
    gnt = 2'b00;
    if (can_grant) begin
      if (!prio) begin
        gnt[0] = rq_read[0];
        gnt[1] = rq_read[1] & ~rq_read[0];
      end else begin
        gnt[1] = rq_read[1];
        gnt[0] = rq_read[0] & ~rq_read[1];
      end
    end
  end

  assign sel            = gnt[1];
  assign rq_waitrequest = ~gnt;

  assign push = (state == S_ISSUE) && !avm_waitrequest;
  assign din  = '{owner: owner_q, beats: avm_burstcount};

  assign hit  = rst_n && avm_readdatavalid && !empty;
  assign last = hit && ((beat_cnt + 8'd1) == head.beats);

  assign rq_readdata      = avm_readdata;
  assign rq_readdatavalid = hit ? (head.owner ? 2'b10 : 2'b01) : 2'b00;

  arb_tag_fifo #(.DEPTH(MAXOUT)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (din),
    .pop   (last),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (outstanding)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      prio           <= 1'b0;
      owner_q        <= 1'b0;
      avm_read       <= 1'b0;
      avm_address    <= '0;
      avm_burstcount <= 8'd1;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (|gnt) begin
            owner_q     <= sel;
            prio        <= ~sel;
            avm_address <= rq_address[sel];
            avm_read    <= 1'b1;
            state       <= S_ISSUE;
            // a zero-length request still moves one beat
            avm_burstcount <= (rq_burstcount[sel] == 8'd0)
                              ? 8'd1 : rq_burstcount[sel];
          end
        end
        S_ISSUE: begin
          if (!avm_waitrequest) begin
            avm_read <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt   <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (hit) beat_cnt <= last ? 8'd0 : beat_cnt + 8'd1;
      if (avm_readdatavalid && empty) err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_rd_arbiter.sv
// Directed bench for sdram_rd_arbiter: vector table for
// arbitration/return routing plus hand-written corner sequences.
module tb_sdram_rd_arbiter;
  import sdram_arb_pkg::*;

  localparam int BUSW = 128;

  logic             clk;
  logic             rst_n;
  logic [1:0][31:0] rq_address;
  logic [1:0]       rq_read;
  logic [1:0][7:0]  rq_burstcount;
  logic [1:0]       rq_waitrequest;
  logic [BUSW-1:0]  rq_readdata;
  logic [1:0]       rq_readdatavalid;
  logic [31:0]      avm_address;
  logic             avm_read;
  logic [7:0]       avm_burstcount;
  logic [BUSW-1:0]  avm_readdata;
  logic             avm_readdatavalid;
  logic             avm_waitrequest;
  logic [2:0]       outstanding;
  logic             err_orphan;

  int checks = 0;
  int errors = 0;

  sdram_rd_arbiter #(.BUSW(BUSW), .MAXOUT(4)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .rq_address        (rq_address),
    .rq_read           (rq_read),
    .rq_burstcount     (rq_burstcount),
    .rq_waitrequest    (rq_waitrequest),
    .rq_readdata       (rq_readdata),
    .rq_readdatavalid  (rq_readdatavalid),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_burstcount    (avm_burstcount),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .avm_waitrequest   (avm_waitrequest),
    .outstanding       (outstanding),
    .err_orphan        (err_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  rd;
    logic        rdv;
    logic [31:0] a0;
    logic [7:0]  b0;
    logic [1:0]  wr;
    logic        ar;
    logic [31:0] addr;
    logic [7:0]  bc;
    logic [2:0]  out;
    logic [1:0]  qv;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic [1:0] rd, input logic rdv,
    input logic [31:0] a0, input logic [7:0] b0,
    input logic [1:0] wr, input logic ar,
    input logic [31:0] addr, input logic [7:0] bc,
    input logic [2:0] out, input logic [1:0] qv);
    vec_t v;
    v.rd = rd; v.rdv = rdv; v.a0 = a0; v.b0 = b0;
    v.wr = wr; v.ar = ar; v.addr = addr; v.bc = bc;
    v.out = out; v.qv = qv;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int o, input logic [31:0] a,
                       input logic [7:0] b);
    int n;
    n = 0;
    rq_address[o]    = a;
    rq_burstcount[o] = b;
    rq_read[o]       = 1'b1;
    #1;
    while (rq_waitrequest[o] && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("grant_timeout", 128'(rq_waitrequest[o]), 128'(0));
    step();
    rq_read[o] = 1'b0;
  endtask

  function automatic logic [BUSW-1:0] pat(input int i);
    return {4{32'hD000_0000 + 32'(i)}};
  endfunction

  initial begin
    rst_n             = 1'b0;
    rq_address        = '0;
    rq_read           = 2'b00;
    rq_burstcount     = '0;
    avm_readdata      = '0;
    avm_readdatavalid = 1'b1;
    avm_waitrequest   = 1'b0;

    // reset state
    rq_read = 2'b11;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_wr", 128'(rq_waitrequest), 128'(2'b11));
    chk("rst_qv", 128'(rq_readdatavalid), 128'(2'b00));
    chk("rst_ar", 128'(avm_read), 128'(0));
    chk("rst_addr", 128'(avm_address), 128'(0));
    chk("rst_bc", 128'(avm_burstcount), 128'(1));
    chk("rst_out", 128'(outstanding), 128'(0));
    chk("rst_err", 128'(err_orphan), 128'(0));
    @(posedge clk);
    #1;
    rq_read = 2'b00;
    avm_readdatavalid = 1'b0;
    rst_n = 1'b1;
    step();

    // single burst from requester 0
    issue(0, 32'h100, 8'd4);
    #1;
    chk("s1_ar", 128'(avm_read), 128'(1));
    chk("s1_addr", 128'(avm_address), 128'(32'h100));
    chk("s1_bc", 128'(avm_burstcount), 128'(4));
    chk("s1_out0", 128'(outstanding), 128'(0));
    step();
    #1;
    chk("s1_ar_drop", 128'(avm_read), 128'(0));
    chk("s1_out1", 128'(outstanding), 128'(1));
    for (int i = 0; i < 4; i++) begin
      avm_readdatavalid = 1'b1;
      avm_readdata = pat(i);
      #1;
      chk("s1_qv", 128'(rq_readdatavalid), 128'(2'b01));
      chk("s1_data", rq_readdata, pat(i));
      step();
    end
    avm_readdatavalid = 1'b0;
    #1;
    chk("s1_out_end", 128'(outstanding), 128'(0));
    chk("s1_qv_end", 128'(rq_readdatavalid), 128'(2'b00));

    // reset mid-burst with a stalled command
    issue(0, 32'h700, 8'd4);
    step();
    avm_readdatavalid = 1'b1;
    #1;
    chk("r_qv", 128'(rq_readdatavalid), 128'(2'b01));
    step();
    avm_readdatavalid = 1'b0;
    avm_waitrequest = 1'b1;
    issue(1, 32'h780, 8'd2);
    #1;
    chk("r_ar_pre", 128'(avm_read), 128'(1));
    chk("r_out_pre", 128'(outstanding), 128'(1));
    step();
    rst_n = 1'b0;
    rq_read = 2'b11;
    avm_readdatavalid = 1'b1;
    #1;
    chk("r_out", 128'(outstanding), 128'(0));
    chk("r_ar", 128'(avm_read), 128'(0));
    chk("r_wr", 128'(rq_waitrequest), 128'(2'b11));
    chk("r_qv0", 128'(rq_readdatavalid), 128'(2'b00));
    chk("r_bc", 128'(avm_burstcount), 128'(1));
    step();
    rst_n = 1'b1;
    rq_read = 2'b00;
    avm_readdatavalid = 1'b0;
    avm_waitrequest = 1'b0;
    step();

    // alternation, full-FIFO stall, ordered return
    rq_address[1] = 32'h300;
    rq_burstcount[1] = 8'd3;
    for (int c = 0; c < 8; c++) begin
      logic [1:0] w;
      logic [31:0] ad;
      logic [7:0] b;
      w = c[0] ? 2'b11 : (c[1] ? 2'b01 : 2'b10);
      ad = c[1] ? 32'h300 : 32'h200;
      b = c[1] ? 8'd3 : 8'd2;
      tbl.push_back(mk(2'b11, 1'b0, 32'h200, 8'd2, w, c[0],
                       ad, b, 3'(c / 2), 2'b00));
    end
    for (int c = 0; c < 3; c++)
      tbl.push_back(mk(2'b01, 0, 32'h400, 1, 2'b11, 0, 0, 0, 4, 2'b00));
    tbl.push_back(mk(2'b01, 1, 32'h400, 1, 2'b11, 0, 0, 0, 4, 2'b01));
    tbl.push_back(mk(2'b01, 1, 32'h400, 1, 2'b11, 0, 0, 0, 4, 2'b01));
    tbl.push_back(mk(2'b01, 1, 32'h400, 1, 2'b10, 0, 0, 0, 3, 2'b10));
    tbl.push_back(mk(2'b00, 1, 32'h400, 1, 2'b11, 1,
                     32'h400, 1, 3, 2'b10));
    tbl.push_back(mk(2'b00, 1, 32'h400, 1, 2'b11, 0, 0, 0, 4, 2'b10));
    tbl.push_back(mk(2'b00, 1, 32'h400, 1, 2'b11, 0, 0, 0, 3, 2'b01));
    tbl.push_back(mk(2'b00, 1, 32'h400, 1, 2'b11, 0, 0, 0, 3, 2'b01));
    for (int c = 0; c < 3; c++)
      tbl.push_back(mk(2'b00, 1, 32'h400, 1, 2'b11, 0, 0, 0, 2, 2'b10));
    tbl.push_back(mk(2'b00, 1, 32'h400, 1, 2'b11, 0, 0, 0, 1, 2'b01));
    tbl.push_back(mk(2'b00, 0, 32'h400, 1, 2'b11, 0, 0, 0, 0, 2'b00));

    foreach (tbl[k]) begin
      rq_read = tbl[k].rd;
      rq_address[0] = tbl[k].a0;
      rq_burstcount[0] = tbl[k].b0;
      avm_readdatavalid = tbl[k].rdv;
      avm_readdata = pat(100 + k);
      #1;
      chk($sformatf("t%0d_wr", k), 128'(rq_waitrequest), 128'(tbl[k].wr));
      chk($sformatf("t%0d_ar", k), 128'(avm_read), 128'(tbl[k].ar));
      if (tbl[k].ar) begin
        chk($sformatf("t%0d_addr", k), 128'(avm_address), 128'(tbl[k].addr));
        chk($sformatf("t%0d_bc", k), 128'(avm_burstcount), 128'(tbl[k].bc));
      end
      chk($sformatf("t%0d_out", k), 128'(outstanding), 128'(tbl[k].out));
      chk($sformatf("t%0d_qv", k), 128'(rq_readdatavalid), 128'(tbl[k].qv));
      if (tbl[k].rdv)
        chk($sformatf("t%0d_data", k), rq_readdata, pat(100 + k));
      step();
    end
    rq_read = 2'b00;
    avm_readdatavalid = 1'b0;

    // downstream stall holds the command stable
    avm_waitrequest = 1'b1;
    issue(1, 32'h500, 8'd8);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("st_ar", 128'(avm_read), 128'(1));
      chk("st_addr", 128'(avm_address), 128'(32'h500));
      chk("st_bc", 128'(avm_burstcount), 128'(8));
      step();
    end
    avm_waitrequest = 1'b0;
    #1;
    chk("st_ar_acc", 128'(avm_read), 128'(1));
    chk("st_out_acc", 128'(outstanding), 128'(0));
    step();
    #1;
    chk("st_ar_drop", 128'(avm_read), 128'(0));
    chk("st_out", 128'(outstanding), 128'(1));
    for (int i = 0; i < 6; i++) begin
      avm_readdatavalid = 1'b1;
      #1;
      chk("st_qv", 128'(rq_readdatavalid), 128'(2'b10));
      step();
    end

    // zero-length request pushed on the same edge the head pops
    rq_address[0] = 32'h600;
    rq_burstcount[0] = 8'd0;
    rq_read[0] = 1'b1;
    #1;
    chk("z_wr", 128'(rq_waitrequest), 128'(2'b10));
    chk("z_qv6", 128'(rq_readdatavalid), 128'(2'b10));
    step();
    rq_read[0] = 1'b0;
    #1;
    chk("z_ar", 128'(avm_read), 128'(1));
    chk("z_bc", 128'(avm_burstcount), 128'(1));
    chk("z_addr", 128'(avm_address), 128'(32'h600));
    chk("z_qv7", 128'(rq_readdatavalid), 128'(2'b10));
    step();
    #1;
    chk("z_out_pp", 128'(outstanding), 128'(1));
    chk("z_qv_own", 128'(rq_readdatavalid), 128'(2'b01));
    step();
    avm_readdatavalid = 1'b0;
    #1;
    chk("z_out0", 128'(outstanding), 128'(0));
    chk("z_err0", 128'(err_orphan), 128'(0));
    step();

    // stray beat with nothing outstanding
    avm_readdatavalid = 1'b1;
    #1;
    chk("o_qv", 128'(rq_readdatavalid), 128'(2'b00));
    chk("o_err_pre", 128'(err_orphan), 128'(0));
    step();
    avm_readdatavalid = 1'b0;
    #1;
    chk("o_err", 128'(err_orphan), 128'(1));
    chk("o_out", 128'(outstanding), 128'(0));
    repeat (3) step();
    #1;
    chk("o_err_sticky", 128'(err_orphan), 128'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
